// File: rtl/mpg_sector_writer.sv
// Sequential sector writer: buffers a byte stream in a circular cache and hands
// full 512-byte sectors to the HPS through the hps_io sd_* write handshake.
module mpg_sector_writer #(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] max_sectors,
    input  logic        flush,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] sd_lba,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [13:0] sd_buff_addr,
    output logic [7:0]  sd_buff_din,
    output logic        active,
    output logic        done,
    output logic        overflow,
    output logic [31:0] sectors_written
);

    localparam int unsigned SECTOR_SIZE = 512;
    localparam int unsigned SEC_W       = 9;
    localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
    localparam int unsigned LVL_W       = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W       = 32;
    localparam int unsigned ACC_W       = CNT_W + SEC_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAD   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [ACC_W-1:0]      accepted_q, accepted_d;
    logic [CNT_W-1:0]      next_lba_q, next_lba_d;
    logic [CNT_W-1:0]      max_sectors_q, max_sectors_d;
    logic                  pending_q, pending_d;
    logic                  sd_ack_q, sd_ack_d;
    logic                  in_ready_q, in_ready_d;
    logic [CNT_W-1:0]      sd_lba_q, sd_lba_d;
    logic                  sd_wr_q, sd_wr_d;
    logic [7:0]            sd_buff_din_q, sd_buff_din_d;
    logic                  active_q, active_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_W-1:0]      sectors_written_q, sectors_written_d;

    logic                  accept_c;
    logic                  pad_wr_c;
    logic                  ack_fall_c;
    logic                  busy_c;
    logic                  req_c;
    logic                  cache_we_c;
    logic [7:0]            cache_wdata_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c;
    logic [ACC_W-1:0]      cap_c;
    logic                  addr_hi_unused;

    logic [7:0] cache_mem [DEPTH];

    // Only the in-sector byte offset of the HPS buffer address is meaningful.
    assign addr_hi_unused = ^sd_buff_addr[13:SEC_W];

    always_comb begin
        state_d           = state_q;
        wr_ptr_d          = wr_ptr_q;
        rd_base_d         = rd_base_q;
        level_d           = level_q;
        accepted_d        = accepted_q;
        next_lba_d        = next_lba_q;
        max_sectors_d     = max_sectors_q;
        pending_d         = pending_q;
        sd_ack_d          = sd_ack;
        sd_lba_d          = sd_lba_q;
        sd_wr_d           = sd_wr_q;
        done_d            = done_q;
        overflow_d        = overflow_q;
        sectors_written_d = sectors_written_q;

        cap_c      = {max_sectors_q, SEC_W'(0)};
        busy_c     = (state_q == S_RUN) || (state_q == S_PAD) || (state_q == S_DRAIN);
        accept_c   = (state_q == S_RUN) && in_ready_q && in_valid;
        pad_wr_c   = (state_q == S_PAD) && (level_q < LVL_W'(DEPTH));
        ack_fall_c = sd_ack_q && !sd_ack && pending_q;
        req_c      = busy_c && !pending_q && !sd_ack
                     && (level_q >= LVL_W'(SECTOR_SIZE)) && (next_lba_q < max_sectors_q);

        cache_we_c    = accept_c || pad_wr_c;
        cache_wdata_c = accept_c ? in_data : 8'h00;
        rd_addr_c     = rd_base_q + ADDR_WIDTH'(sd_buff_addr[SEC_W-1:0]);
        sd_buff_din_d = cache_mem[rd_addr_c];

        // Input side: stream bytes and pad zeros share the write pointer.
        if (cache_we_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (accept_c) begin
            accepted_d = accepted_q + ACC_W'(1);
        end
        level_d = level_q + LVL_W'(cache_we_c) - (ack_fall_c ? LVL_W'(SECTOR_SIZE) : LVL_W'(0));
        if ((state_q == S_RUN) && in_valid && (accepted_q >= cap_c)) begin
            overflow_d = 1'b1;
        end

        if (sd_wr_q && sd_ack) begin
            sd_wr_d = 1'b0;
        end
        if (req_c) begin
            sd_lba_d  = next_lba_q;
            sd_wr_d   = 1'b1;
            pending_d = 1'b1;
        end
        if (ack_fall_c) begin
            rd_base_d         = rd_base_q + ADDR_WIDTH'(SECTOR_SIZE);
            next_lba_d        = next_lba_q + CNT_W'(1);
            sectors_written_d = sectors_written_q + CNT_W'(1);
            pending_d         = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RUN: begin
                // Decide on the post-accept pointer so a byte taken with flush is not stranded.
                if (flush) begin
                    state_d = (wr_ptr_d[SEC_W-1:0] != '0) ? S_PAD : S_DRAIN;
                end
            end
            S_PAD: begin
                if (pad_wr_c && (wr_ptr_q[SEC_W-1:0] == SEC_W'(SECTOR_SIZE - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((level_q == '0) && !pending_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Restart wins over everything else in the cycle.
        if (start) begin
            state_d           = S_RUN;
            wr_ptr_d          = '0;
            rd_base_d         = '0;
            level_d           = '0;
            accepted_d        = '0;
            next_lba_d        = '0;
            max_sectors_d     = max_sectors;
            pending_d         = 1'b0;
            sd_lba_d          = '0;
            sd_wr_d           = 1'b0;
            done_d            = 1'b0;
            overflow_d        = 1'b0;
            sectors_written_d = '0;
            cache_we_c        = 1'b0;
        end

        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end
        active_d   = (state_d == S_RUN) || (state_d == S_PAD) || (state_d == S_DRAIN);
        in_ready_d = (state_d == S_RUN) && (level_d < LVL_W'(DEPTH))
                     && (accepted_d < {max_sectors_d, SEC_W'(0)});
    end

    // Sector cache storage; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (cache_we_c) begin
            cache_mem[wr_ptr_q] <= cache_wdata_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            wr_ptr_q          <= '0;
            rd_base_q         <= '0;
            level_q           <= '0;
            accepted_q        <= '0;
            next_lba_q        <= '0;
            max_sectors_q     <= '0;
            pending_q         <= 1'b0;
            sd_ack_q          <= 1'b0;
            in_ready_q        <= 1'b0;
            sd_lba_q          <= '0;
            sd_wr_q           <= 1'b0;
            sd_buff_din_q     <= '0;
            active_q          <= 1'b0;
            done_q            <= 1'b0;
            overflow_q        <= 1'b0;
            sectors_written_q <= '0;
        end else begin
            state_q           <= state_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_base_q         <= rd_base_d;
            level_q           <= level_d;
            accepted_q        <= accepted_d;
            next_lba_q        <= next_lba_d;
            max_sectors_q     <= max_sectors_d;
            pending_q         <= pending_d;
            sd_ack_q          <= sd_ack_d;
            in_ready_q        <= in_ready_d;
            sd_lba_q          <= sd_lba_d;
            sd_wr_q           <= sd_wr_d;
            sd_buff_din_q     <= sd_buff_din_d;
            active_q          <= active_d;
            done_q            <= done_d;
            overflow_q        <= overflow_d;
            sectors_written_q <= sectors_written_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign sd_lba          = sd_lba_q;
    assign sd_wr           = sd_wr_q;
    assign sd_buff_din     = sd_buff_din_q;
    assign active          = active_q;
    assign done            = done_q;
    assign overflow        = overflow_q;
    assign sectors_written = sectors_written_q;

endmodule

// File: tb/tb_mpg_sector_writer.sv
// Bench for mpg_sector_writer: random byte stream into a byte-queue reference,
// with an independent HPS process that serves sectors and checks every byte.
module tb_mpg_sector_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] max_sectors;
    logic        flush;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] sd_lba;
    logic        sd_wr;
    logic        sd_ack;
    logic [13:0] sd_buff_addr;
    logic [7:0]  sd_buff_din;
    logic        active;
    logic        done;
    logic        overflow;
    logic [31:0] sectors_written;

    mpg_sector_writer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .max_sectors     (max_sectors),
        .flush           (flush),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .sd_lba          (sd_lba),
        .sd_wr           (sd_wr),
        .sd_ack          (sd_ack),
        .sd_buff_addr    (sd_buff_addr),
        .sd_buff_din     (sd_buff_din),
        .active          (active),
        .done            (done),
        .overflow        (overflow),
        .sectors_written (sectors_written)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the byte sequence the HPS must see, in sector order.
    logic [7:0] exp_q[$];
    int         exp_lba    = 0;
    int         exp_sw     = 0;
    int         acc_total  = 0;
    int         hps_budget = 0;
    bit         abort_mode = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // HPS model / monitor: answers sd_wr and compares every served byte.
    initial begin
        sd_ack       = 1'b0;
        sd_buff_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (sd_wr && hps_budget > 0) begin
                hps_budget--;
                chk("req_lba", sd_lba, exp_lba);
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                sd_ack = 1'b1;
                @(posedge clk); #1;
                chk("wr_clear", sd_wr, 0);
                if (abort_mode) begin
                    while (abort_mode) begin @(posedge clk); #1; end
                    sd_ack = 1'b0;
                end else begin
                    for (int a = 0; a < 512; a++) begin
                        sd_buff_addr = 14'(a);
                        @(posedge clk); #1;
                        chk("model_nonempty", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) chk("sd_buff_din", sd_buff_din, exp_q.pop_front());
                    end
                    chk("lba_hold", sd_lba, exp_lba);
                    sd_ack = 1'b0;
                    exp_lba++;
                    exp_sw++;
                    @(posedge clk); #1;
                    chk("sectors_written", sectors_written, exp_sw);
                end
            end
        end
    end

    task automatic push_bytes(input int n, input int budget, input int vpct, input bit ramp,
                              output int got);
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(1, 100) <= vpct);
            in_data  = ramp ? 8'(acc_total) : 8'($urandom);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                acc_total++;
                got++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int m);
        @(posedge clk); #1;
        start       = 1'b1;
        max_sectors = 32'(m);
        exp_q.delete();
        exp_lba   = 0;
        exp_sw    = 0;
        acc_total = 0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ready", in_ready, int'(m != 0));
        chk("start_active", active, 1);
        chk("start_done", done, 0);
        chk("start_sw", sectors_written, 0);
    endtask

    task automatic do_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        for (int i = 0; i < (512 - acc_total % 512) % 512; i++) exp_q.push_back(8'h00);
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done && c < budget) begin @(posedge clk); #1; c++; end
        chk("done", done, 1);
        chk("done_ready", in_ready, 0);
        chk("done_active", active, 0);
    endtask

    task automatic wait_sw(input int target, input int budget);
        int c = 0;
        while (sectors_written != 32'(target) && c < budget) begin @(posedge clk); #1; c++; end
        chk("sw_wait", sectors_written, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int got;
        int cycles;
        int seen;
        rst_n = 1'b0; start = 1'b0; max_sectors = '0; flush = 1'b0;
        in_data = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_sd_lba", sd_lba, 0);
        chk("rst_din", sd_buff_din, 0);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sw", sectors_written, 0);
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("idle_ready", in_ready, 0);

        // Continuous ramp write of two sectors.
        hps_budget = 1000;
        do_start(8);
        push_bytes(1024, 1200, 100, 1'b1, got);
        chk("t1_got", got, 1024);
        wait_sw(2, 2000);

        // Partial sector flush: padding duration seen through the next request.
        do_start(8);
        hps_budget = 1000;
        push_bytes(700, 2000, 70, 1'b0, got);
        chk("t2_got", got, 700);
        wait_sw(1, 2000);
        hps_budget = 0;
        do_flush();
        cycles = 1;
        while (!sd_wr && cycles < 1000) begin @(posedge clk); #1; cycles++; end
        chk("pad_time", cycles, 512 - 188 + 2);
        chk("pad_ready", in_ready, 0);
        hps_budget = 1;
        while (sectors_written != 32'd2 && cycles < 3000) begin @(posedge clk); #1; cycles++; end
        chk("t2_sw", sectors_written, 2);
        chk("done_early", done, 0);
        @(posedge clk); #1;
        chk("done_latency", done, 1);
        wait_done(10);

        // Full buffer backpressure and single-sector release.
        hps_budget = 0;
        do_start(64);
        push_bytes(16384 + 64, 16384 + 200, 100, 1'b0, got);
        chk("t3_fill", got, 16384);
        chk("t3_full_ready", in_ready, 0);
        hps_budget = 1;
        push_bytes(1024, 1600, 100, 1'b0, got);
        chk("t3_refill", got, 512);
        hps_budget = 1000;
        do_flush();
        wait_done(40000);
        chk("t3_sw", sectors_written, 33);

        // Capacity limit.
        do_start(2);
        push_bytes(1500, 3000, 80, 1'b0, got);
        chk("t4_got", got, 1024);
        chk("t4_overflow", overflow, 1);
        wait_sw(2, 3000);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (sd_wr) seen++; end
        chk("t4_no_lba2", seen, 0);
        do_flush();
        wait_done(20);

        // Zero capacity: nothing accepted, flush completes at once.
        do_start(0);
        push_bytes(10, 20, 100, 1'b0, got);
        chk("t0_got", got, 0);
        chk("t0_overflow", overflow, 1);
        do_flush();
        wait_done(10);

        // Aligned flush: no padding, one write.
        do_start(4);
        push_bytes(512, 1000, 90, 1'b0, got);
        chk("t5_got", got, 512);
        do_flush();
        wait_done(2000);
        chk("t5_sw", sectors_written, 1);
        chk("t5_model_empty", exp_q.size(), 0);

        // Restart while the HPS holds sd_ack.
        hps_budget = 1;
        do_start(8);
        push_bytes(1024, 3000, 100, 1'b0, got);
        wait_sw(1, 2000);
        abort_mode = 1;
        hps_budget = 1;
        cycles = 0;
        while (!sd_ack && cycles < 100) begin @(posedge clk); #1; cycles++; end
        chk("t6_ack_seen", sd_ack, 1);
        do_start(8);
        chk("t6_wr_drop", sd_wr, 0);
        abort_mode = 0;
        repeat (6) begin @(posedge clk); #1; end
        chk("t6_late_ack", sectors_written, 0);
        hps_budget = 1000;
        push_bytes(512, 1000, 100, 1'b0, got);
        wait_sw(1, 2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mpg_sector_writer.md
# mpg_sector_writer

Sequential sector writer for MiSTer image files: the write-direction counterpart of the MPEG2 sector streamer. It accepts a byte stream with ready/valid (e.g. decoder output dumps or capture data) into a 16 KB circular BRAM. Each time a full 512-byte sector is buffered, it issues an `sd_wr` request on the hps_io `sd_*` interface and serves the bytes to the HPS through `sd_buff_addr`/`sd_buff_din`. A flush command zero-pads the last partial sector and writes it, then reports completion.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: cache address width; cache holds 2^14 bytes (32 sectors).
- `SECTOR_SIZE`, 512: bytes per sector (hps_io BLKSZ=2); fixed, not overridable.

Ports:
- `clk` in 1: core clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: pulse; clears all state and begins writing at LBA 0.
- `max_sectors` in 32: image capacity in sectors; sampled on `start`.
- `flush` in 1: pulse; pad the partial sector, drain everything, then signal done.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `sd_lba` out 32: sector address of the current write request.
- `sd_wr` out 1: write request to hps_io.
- `sd_ack` in 1: HPS transfer in progress.
- `sd_buff_addr` in 14: byte index within the sector; only bits [8:0] are used.
- `sd_buff_din` out 8: byte served to the HPS.
- `active` out 1: writer running (RUN, PAD or DRAIN).
- `done` out 1: sticky; set on entering DONE, cleared by `start`/reset.
- `overflow` out 1: sticky; `in_valid` seen while the capacity limit blocks input.
- `sectors_written` out 32: count of completed sector transfers.

## Operation
- **State:**
  - `wr_ptr` (14b): input write address.
  - `rd_base` (14b): base address of the sector being served.
  - `level` (15b, 0..16384): bytes buffered, not yet written.
  - `accepted` (41b): total bytes accepted.
  - `next_lba` (32b).
  - `pending` (1b).
- **States:**
  - **IDLE:** after reset; ignores input and flush.
  - **RUN:** accepts bytes.
    - `in_ready = (level < 16384) && (accepted < max_sectors*512)`.
    - `flush`: if `wr_ptr[8:0] != 0`, go to PAD; else go to DRAIN.
  - **PAD:** writes one 0x00 byte per cycle at `wr_ptr` while `level < 16384`, with `in_ready=0`. Goes to DRAIN in the cycle `wr_ptr[8:0]` wraps to 0.
  - **DRAIN:** `in_ready=0`. Goes to DONE when `level == 0 && !pending`.
  - **DONE:** `in_ready=0` and `done=1`. Stays in DONE until `start`.
- **Accept:** writes `cache[wr_ptr] <= in_data`, then `wr_ptr++`, `level++`, `accepted++`.
- **Request:** in RUN/PAD/DRAIN, when `!pending && !sd_ack && level >= 512 && next_lba < max_sectors`:
  - set `sd_lba <= next_lba`, `sd_wr <= 1`, `pending <= 1`.
- **Ack handling:**
  - `sd_wr` clears in the first cycle `sd_ack` is seen high.
  - `sd_lba` is held stable from request until the `sd_ack` falling edge.
- **Completion:** on the `sd_ack` falling edge (registered compare):
  - `rd_base += 512`, `level -= 512`, `next_lba++`, `sectors_written++`, `pending <= 0`.
- **Read port:** `sd_buff_din <= cache[rd_base + sd_buff_addr[8:0]]`, registered, 1-cycle latency. It is updated every cycle, independent of `sd_ack`.
- **Simultaneous events:**
  - An accept and a completion in the same cycle give a net `level += 1 - 512`.
  - `start` overrides every other input in that cycle.
  - `flush` outside RUN is ignored.
- **Capacity limit:** total accepted bytes never exceed `max_sectors*512`. `max_sectors=0` means nothing is accepted and `flush` goes straight to DONE.
- **Pointer arithmetic:** wraps modulo 2^14. `level` disambiguates full (16384) from empty (0).
- **Restart:** `start` mid-transfer drops `sd_wr` and `pending` immediately and resets all state. A late `sd_ack` falling edge after `start` is ignored (no pending request).

## Timing
- **Reset values:** `in_ready=0`, `sd_wr=0`, `sd_lba=0`, `sd_buff_din=0`, `active=0`, `done=0`, `overflow=0`, `sectors_written=0`. State is IDLE.
- **Start latency:** `start` at cycle N gives `in_ready=1` and `active=1` at N+1.
- **Request latency:** `sd_wr` rises 1 cycle after `level` reaches 512, if eligible.
- **Re-request gap:** after completion, the earliest next `sd_wr` is 1 cycle after the completion cycle.
- **Padding time:** PAD lasts exactly `512 - wr_ptr[8:0]` cycles absent full-buffer stalls.
- **`done` latency:** rises 1 cycle after the last completion when the flush has drained.
- **Input throughput:** one byte per cycle sustained while `in_ready` is high.

## Test plan
1. **Continuous write:**
   - Stimulus: `start`, `max_sectors=8`, push 1024 bytes `i&0xFF`; HPS model reads addresses 0..511.
   - Required: writes at LBA 0 then 1; each `sd_buff_din` equals `i&0xFF` one cycle after its address; `sectors_written=2`.
2. **Flush with padding:**
   - Stimulus: push 700 bytes, then `flush`.
   - Required: PAD lasts 324 cycles; LBA 1 carries bytes 188..511 = 0x00; `done=1`; `in_ready=0` afterwards.
3. **Full-buffer backpressure:**
   - Stimulus: HPS never acks; push continuously.
   - Required: `in_ready` drops after 16384 bytes; after one ack sequence it reasserts for exactly 512 more bytes; no data corruption.
4. **Capacity limit:**
   - Stimulus: `max_sectors=2`, offer 1500 bytes.
   - Required: exactly 1024 bytes accepted; `overflow=1`; no request for LBA 2.
5. **Aligned flush:**
   - Stimulus: 512 bytes, then `flush`.
   - Required: no PAD state; one write; `done` set after it completes.
6. **Restart mid-transfer:**
   - Stimulus: `start` asserted while `sd_ack=1`.
   - Required: `sd_wr=0` and `sectors_written=0` next cycle; the late ack falling edge causes no count change; the next write goes to LBA 0.
